// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the three-requester memory port arbiter:
// FSM encoding, requester indices and round-robin selection.
package mem_port_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] REQ_IF   = 2'd0;
  localparam logic [1:0] REQ_MEM  = 2'd1;
  localparam logic [1:0] REQ_DBG  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Modulo-3 successor; the "none" code wraps to requester 0.
  function automatic logic [1:0] idx_next(input logic [1:0] i);
    return (i == REQ_DBG || i == SEL_NONE) ? REQ_IF : i + 2'd1;
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] i);
    logic [2:0] oh;
    case (i)
      REQ_IF:  oh = 3'b001;
      REQ_MEM: oh = 3'b010;
      REQ_DBG: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // First active request searching ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] win;
    c0  = (ptr == SEL_NONE) ? REQ_IF : ptr;
    c1  = idx_next(c0);
    c2  = idx_next(c1);
    win = SEL_NONE;
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
    else if (req[c2]) win = c2;
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled as one bus.
// master: the arbiter itself; slave: requesters plus memory driving it.
interface mem_port_arbiter_if #(parameter int DATA_W = 16);

  logic [2:0]        req;
  logic [2:0]        lock;
  logic [2:0]        we;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        gnt;
  logic [1:0]        sel;
  logic [2:0]        ack;
  logic [2:0]        err;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    input  req, lock, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_ready,
    output gnt, sel, ack, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, lock, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_ready,
    input  gnt, sel, ack, err, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/MUX_3_1_16bit.sv
// Three-input word multiplexer; select code 2'b11 (or any unused code) yields zero.
module MUX_3_1_16bit #(
  parameter int W = 16
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);

  always_comb begin
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among IF, MEM and debug requesters,
// with optional grant locking and a BUSY-cycle timeout.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_port_arbiter_if.master bus
);

  import mem_port_arbiter_pkg::*;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [2:0] gnt_reg, gnt_next;
  logic [2:0] err_reg, err_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       busy, cur_req, cur_we, cur_lock, release_grant;
  logic [1:0] mux_sel, win;

  assign busy = (state_reg == ST_BUSY) && (sel_reg != SEL_NONE);

  always_comb begin
    cur_req  = 1'b0;
    cur_we   = 1'b0;
    cur_lock = 1'b0;
    if (busy) begin
      cur_req  = bus.req[sel_reg];
      cur_we   = bus.we[sel_reg];
      cur_lock = bus.lock[sel_reg];
    end
  end

  assign mux_sel       = busy ? sel_reg : SEL_NONE;
  assign win           = rr_pick(bus.req, ptr_reg);
  assign bus.mem_req   = cur_req;
  assign bus.mem_we    = cur_we;
  assign bus.ack       = (cur_req && bus.mem_ready) ? idx_onehot(sel_reg) : 3'b000;
  assign bus.gnt       = gnt_reg;
  assign bus.sel       = sel_reg;
  assign bus.err       = err_reg;

  MUX_3_1_16bit #(.W(DATA_W)) u_addr_mux (
    .in0 (bus.addr0),
    .in1 (bus.addr1),
    .in2 (bus.addr2),
    .sel (mux_sel),
    .out (bus.mem_addr)
  );

  MUX_3_1_16bit #(.W(DATA_W)) u_wdata_mux (
    .in0 (bus.wdata0),
    .in1 (bus.wdata1),
    .in2 (bus.wdata2),
    .sel (mux_sel),
    .out (bus.mem_wdata)
  );

  // Dropped request wins over mem_ready, which wins over the timeout.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    gnt_next      = gnt_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    err_next      = 3'b000;
    release_grant = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (win != SEL_NONE) begin
        state_next = ST_BUSY;
        sel_next   = win;
        gnt_next   = idx_onehot(win);
        cnt_next   = 8'd0;
      end
    end else if (!cur_req) begin
      release_grant = 1'b1;
    end else if (bus.mem_ready) begin
      if (cur_lock) cnt_next = 8'd0;
      else          release_grant = 1'b1;
    end else if (cnt_reg == TO_LAST) begin
      release_grant = 1'b1;
      err_next      = idx_onehot(sel_reg);
    end else begin
      cnt_next = cnt_reg + 8'd1;
    end
    if (release_grant) begin
      state_next = ST_IDLE;
      sel_next   = SEL_NONE;
      gnt_next   = 3'b000;
      cnt_next   = 8'd0;
      ptr_next   = idx_next(sel_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= SEL_NONE;
      gnt_reg   <= 3'b000;
      err_reg   <= 3'b000;
      ptr_reg   <= REQ_IF;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
      err_reg   <= err_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, locking, timeout,
// request drop and asynchronous reset, against hand-computed values.
module tb_mem_port_arbiter;

  localparam int DATA_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.DATA_W(DATA_W), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic bad_d;
    logic [2:0] exp_b [7];
    exp_b = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

    bus.req = 3'b000; bus.lock = 3'b000; bus.we = 3'b000; bus.mem_ready = 1'b0;
    bus.addr0 = 16'h00A0; bus.addr1 = 16'h0000; bus.addr2 = 16'h00C2;
    bus.wdata0 = 16'h0D00; bus.wdata1 = 16'h0000; bus.wdata2 = 16'h0D22;

    // Reset state, with requests and mem_ready active during reset
    #12;
    bus.req = 3'b011; bus.mem_ready = 1'b1;
    #1;
    chk("rst_gnt", bus.gnt, 3'b000);
    chk("rst_sel", bus.sel, 2'b11);
    chk("rst_err", bus.err, 3'b000);
    chk("rst_ack", bus.ack, 3'b000);
    chk("rst_mreq", bus.mem_req, 1'b0);
    chk("rst_maddr", bus.mem_addr, 16'h0000);
    bus.req = 3'b000; bus.mem_ready = 1'b0;
    step();
    rst_n = 1'b1;

    // Single transfer from requester 0, ready in second BUSY cycle
    step();
    bus.req = 3'b001; bus.we = 3'b001;
    step(); #1;
    chk("a_gnt", bus.gnt, 3'b001);
    chk("a_sel", bus.sel, 2'b00);
    chk("a_mreq", bus.mem_req, 1'b1);
    chk("a_ack_wait", bus.ack, 3'b000);
    step();
    bus.mem_ready = 1'b1;
    #1;
    chk("a_ack", bus.ack, 3'b001);
    chk("a_maddr", bus.mem_addr, 16'h00A0);
    chk("a_mwdata", bus.mem_wdata, 16'h0D00);
    chk("a_mwe", bus.mem_we, 1'b1);
    step();
    bus.req = 3'b000; bus.we = 3'b000; bus.mem_ready = 1'b0;
    #1;
    chk("a_idle_gnt", bus.gnt, 3'b000);
    chk("a_idle_sel", bus.sel, 2'b11);
    chk("a_idle_maddr", bus.mem_addr, 16'h0000);

    // Pulse reset so round-robin restarts at requester 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // All three requesting, no lock, ready always: 0,1,2,0 with IDLE gaps
    bus.req = 3'b111; bus.mem_ready = 1'b1;
    #1;
    chk("b_idle_ack", bus.ack, 3'b000);
    for (int i = 0; i < 7; i++) begin
      step(); #1;
      chk($sformatf("b_gnt%0d", i), bus.gnt, exp_b[i]);
      chk($sformatf("b_ack%0d", i), bus.ack, exp_b[i]);
    end
    bus.req = 3'b000;
    step();

    // Locked requester 1: three back-to-back acks, grant held
    bus.req = 3'b010; bus.lock = 3'b010; bus.we = 3'b010;
    bus.addr1 = 16'h1234; bus.wdata1 = 16'hBEEF; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk($sformatf("c_gnt%0d", i), bus.gnt, 3'b010);
      chk($sformatf("c_ack%0d", i), bus.ack, 3'b010);
      chk($sformatf("c_maddr%0d", i), bus.mem_addr, 16'h1234);
    end
    chk("c_mwdata", bus.mem_wdata, 16'hBEEF);
    bus.lock = 3'b000;
    step(); #1;
    chk("c_release", bus.gnt, 3'b000);
    bus.req = 3'b000; bus.we = 3'b000; bus.mem_ready = 1'b0;

    // Timeout on requester 2 after 255 BUSY cycles without ready
    bus.req = 3'b100;
    step(); #1;
    chk("d_gnt", bus.gnt, 3'b100);
    bad_d = 1'b0;
    for (int i = 2; i <= 255; i++) begin
      step(); #1;
      if (bus.ack != 3'b000 || bus.err != 3'b000 || bus.gnt != 3'b100) bad_d = 1'b1;
    end
    chk("d_hold", bad_d, 1'b0);
    step(); #1;
    chk("d_err", bus.err, 3'b100);
    chk("d_gnt_after", bus.gnt, 3'b000);
    chk("d_ack", bus.ack, 3'b000);
    bus.req = 3'b000;
    step(); #1;
    chk("d_err_pulse", bus.err, 3'b000);

    // Async reset mid-transfer, then requester 0 wins first
    bus.req = 3'b011; bus.mem_ready = 1'b1;
    step(); #1;
    chk("e_gnt0", bus.gnt, 3'b001);
    step();
    bus.mem_ready = 1'b0;
    step(); #1;
    chk("e_gnt1", bus.gnt, 3'b010);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("e_rst_gnt", bus.gnt, 3'b000);
    chk("e_rst_sel", bus.sel, 2'b11);
    chk("e_rst_mreq", bus.mem_req, 1'b0);
    chk("e_rst_ack", bus.ack, 3'b000);
    bus.mem_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step(); #1;
    chk("e_first", bus.gnt, 3'b001);
    bus.req = 3'b000;
    step();

    // Requester 1 drops request, only requester 0 pending
    bus.req = 3'b011;
    step(); #1;
    chk("f_gnt1", bus.gnt, 3'b010);
    bus.req = 3'b001;
    #1;
    chk("f_drop_ack", bus.ack, 3'b000);
    step(); #1;
    chk("f_idle_gnt", bus.gnt, 3'b000);
    chk("f_idle_err", bus.err, 3'b000);
    step(); #1;
    chk("f_next0", bus.gnt, 3'b001);
    bus.req = 3'b000;
    step();

    // Same drop but with requester 2 also pending
    bus.req = 3'b011;
    step(); #1;
    chk("g_gnt1", bus.gnt, 3'b010);
    bus.req = 3'b101;
    step(); #1;
    chk("g_idle_gnt", bus.gnt, 3'b000);
    step(); #1;
    chk("g_next2", bus.gnt, 3'b100);
    bus.req = 3'b000;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning address/data width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max BUSY cycles without mem_ready (8-bit counter).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-004 req input 3: per-requester access request (0=IF, 1=MEM, 2=debug).
REQ-005 lock input 3: per-requester hold-grant request, sampled at ack.
REQ-006 addr0/addr1/addr2 input DATA_W each: requester addresses.
REQ-007 wdata0/wdata1/wdata2 input DATA_W each: requester write data.
REQ-008 we input 3: per-requester write enable.
REQ-009 gnt output 3: one-hot grant, registered.
REQ-010 sel output 2: mux select (00/01/10 = requester 0/1/2; 11 = none), registered.
REQ-011 ack output 3: one-cycle transfer-complete per requester.
REQ-012 err output 3: one-cycle timeout pulse per requester, registered.
REQ-013 mem_req output 1, mem_we output 1, mem_addr output DATA_W, mem_wdata output DATA_W: shared memory port.
REQ-014 mem_ready input 1: memory completes the transfer this cycle.

Function
REQ-015 FSM SHALL have two states: IDLE, BUSY.
REQ-016 IDLE with req!=0: next cycle BUSY, gnt/sel set to the winner; IDLE with req==0: stay IDLE.
REQ-017 Winner SHALL be round-robin: first requester with req=1 searching from ptr, ptr+1, ptr+2 (mod 3).
REQ-018 ptr SHALL become (granted index + 1) mod 3 whenever a grant is released.
REQ-019 In BUSY: mem_req = req[sel]; mem_we = we[sel]; mem_addr/mem_wdata = addr/wdata of selected requester (combinational through sel).
REQ-020 In IDLE or sel=11: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-021 ack[sel] = BUSY & req[sel] & mem_ready, combinational, same cycle; other ack bits 0.
REQ-022 On ack with lock[sel]=1: stay BUSY, same grant, timeout counter cleared, ptr unchanged.
REQ-023 On ack with lock[sel]=0: next cycle IDLE, gnt=000, sel=11, ptr advances (one turnaround cycle between grants).
REQ-024 Granted requester dropping req in BUSY: next cycle IDLE, no ack, no err, ptr advances.
REQ-025 Timeout counter SHALL increment each BUSY cycle without mem_ready, clear on entry to BUSY and on ack.
REQ-026 Counter reaching TIMEOUT without mem_ready: err[sel] pulses next cycle, state IDLE, gnt=000, ptr advances, no ack.
REQ-027 mem_ready in IDLE SHALL be ignored.
REQ-028 Requests from non-granted requesters SHALL wait; no preemption.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, gnt=000, sel=11, err=000, ptr=0, counter=0.
REQ-030 Combinational outputs during reset: ack=000, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset mid-transfer SHALL abort with no ack/err; first post-reset arbitration starts at requester 0.

Structure
REQ-032 Shared package SHALL hold state encoding (IDLE, BUSY), SEL_NONE=2'b11, requester index constants.
REQ-033 Address and write-data paths SHALL each instantiate the existing sub-module MUX_3_1_16bit (sel=11 yields zero).

Verification
REQ-034 Reset, then req=001, mem_ready=1 in 2nd BUSY cycle -> gnt=001, sel=00, ack=001 that cycle, then IDLE, ptr=1.
REQ-035 req=111 held, lock=0, mem_ready=1 always -> grants 0,1,2,0 each with one IDLE cycle between.
REQ-036 req=010, lock=010, addr1=0x1234, three acks -> gnt=010 held throughout, mem_addr=0x1234, no IDLE gap.
REQ-037 req=100, mem_ready=0 for 255 cycles -> err=100 one pulse, ack never set, gnt=000 after.
REQ-038 rst_n low during BUSY with req=011 -> gnt=000, sel=11, mem_req=0 immediately; after release requester 0 granted first.
REQ-039 Granted requester 1 drops req before mem_ready, req0 pending -> no ack, IDLE one cycle, then gnt=100 only if req2 set, else gnt=001.
